hilo_muldiv_unit: RTL

- Iterative multiply/divide unit with the architectural HI/LO register pair, in the EX stage beside the main ALU.
- Consumes the 4-bit ALU control code and the HI/LO write/read/select strobes from the ALU control decode, plus the two register operands.
- Drives a stall (busy) to the pipeline and supplies HI or LO to the MEM-stage result mux for mfhi/mflo.

---
 rtl/hilo_muldiv_unit_if.sv | 32 +++
 rtl/hilo_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit_if
//  Description : EX-stage request / response bundle between the pipeline and
//                the HI/LO multiply-divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             hiloW;
    logic [3:0]       con;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             hiloR;
    logic             hiloS;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] hiloData;

    modport master (
        output hiloW, con, srcA, srcB, hiloR, hiloS,
        input  busy, done, divZero, hiloData
    );

    modport slave (
        input  hiloW, con, srcA, srcB, hiloR, hiloS,
        output busy, done, divZero, hiloData
    );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit
//  Description : Iterative shift-add multiplier / restoring divider owning the
//                architectural HI/LO pair; stalls EX while an op is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hilo_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] c_last = CNTW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_rem;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    // Request decode; only the 11xx codes belong to this unit
    logic             w_is_op;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_b_zero;
    logic             w_start;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_is_op     = (bus.con[3:2] == 2'b11);
    assign w_is_div    = bus.con[0];
    assign w_is_signed = bus.con[1];
    assign w_b_zero    = (bus.srcB == '0);
    assign w_start     = bus.hiloW && w_is_op && !r_busy && (r_state == S_IDLE);
    assign w_neg_a     = w_is_signed && bus.srcA[WIDTH-1];
    assign w_neg_b     = w_is_signed && bus.srcB[WIDTH-1];
    assign w_mag_a     = w_neg_a ? -bus.srcA : bus.srcA;
    assign w_mag_b     = w_neg_b ? -bus.srcB : bus.srcB;

    // Multiply step: conditional add into the upper half, then shift right
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: dividend bits shift out of r_acc[WIDTH-1:0] while
    // quotient bits shift in from the bottom of the same field
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_trial;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_shift   = {r_rem, r_acc[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_opnd});
    assign w_trial   = w_shift[WIDTH-1:0] - r_opnd;
    assign w_quo_nxt = {r_acc[WIDTH-2:0], w_ge};

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start && !(w_is_div && w_b_zero)) begin
                    w_state_nxt = w_is_div ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_rem      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A divide by zero still occupies one busy cycle so the
                    // done/divZero pulse lands while the pipeline is frozen
                    r_busy <= w_start;
                    if (w_start) begin
                        if (w_is_div && w_b_zero) begin
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_is_div <= w_is_div;
                            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_neg_q  <= w_neg_a ^ w_neg_b;
                            r_neg_r  <= w_neg_a;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + CNTW'(1);
                end
                S_DIV: begin
                    r_rem             <= w_ge ? w_trial : w_shift[WIDTH-1:0];
                    r_acc[WIDTH-1:0]  <= w_quo_nxt;
                    r_cnt             <= r_cnt + CNTW'(1);
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_cnt  <= '0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.divZero  = r_div_zero;
    assign bus.hiloData = bus.hiloR ? (bus.hiloS ? r_lo : r_hi) : '0;

endmodule
`default_nettype wire
